// File: rtl/tetris_pkg.sv
// Shared Tetris definitions: playfield geometry defaults, piece index
// encoding, 9-bit RRR_GGG_BBB palette constants and board sequencer states.
package tetris_pkg;

  localparam int DEF_COLS  = 10;
  localparam int DEF_ROWS  = 20;
  localparam int DEF_CELL  = 20;
  localparam int DEF_ORG_X = 220;
  localparam int DEF_ORG_Y = 40;

  typedef enum logic [2:0] {
    PC_EMPTY = 3'd0,
    PC_I     = 3'd1,
    PC_O     = 3'd2,
    PC_T     = 3'd3,
    PC_S     = 3'd4,
    PC_Z     = 3'd5,
    PC_J     = 3'd6,
    PC_L     = 3'd7
  } piece_e;

  localparam logic [8:0] CLR_BG = 9'b000_000_000;
  localparam logic [8:0] CLR_I  = 9'b000_111_111;
  localparam logic [8:0] CLR_O  = 9'b111_111_000;
  localparam logic [8:0] CLR_T  = 9'b101_000_111;
  localparam logic [8:0] CLR_S  = 9'b000_111_000;
  localparam logic [8:0] CLR_Z  = 9'b111_000_000;
  localparam logic [8:0] CLR_J  = 9'b000_000_111;
  localparam logic [8:0] CLR_L  = 9'b111_100_000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_LATCH = 3'd2,
    ST_ISSUE = 3'd3,
    ST_WAIT  = 3'd4,
    ST_ADV   = 3'd5,
    ST_FIN   = 3'd6
  } state_e;

endpackage

// File: rtl/tetris_palette.sv
// Combinational piece-index to 9-bit colour lookup; empty cells map to
// the background colour.
module tetris_palette
  import tetris_pkg::*;
(
  input  logic [2:0] i_idx,
  output logic [8:0] o_color
);

  always_comb begin
    o_color = CLR_BG;
    case (piece_e'(i_idx))
      PC_I:    o_color = CLR_I;
      PC_O:    o_color = CLR_O;
      PC_T:    o_color = CLR_T;
      PC_S:    o_color = CLR_S;
      PC_Z:    o_color = CLR_Z;
      PC_J:    o_color = CLR_J;
      PC_L:    o_color = CLR_L;
      default: o_color = CLR_BG;
    endcase
  end

endmodule

// File: rtl/board_draw_seq.sv
// Walks the playfield row-major on a frame request and issues one box-draw
// command per cell to the renderer, waiting for its done between cells.
module board_draw_seq
  import tetris_pkg::*;
#(
  parameter int COLS  = DEF_COLS,
  parameter int ROWS  = DEF_ROWS,
  parameter int CELL  = DEF_CELL,
  parameter int ORG_X = DEF_ORG_X,
  parameter int ORG_Y = DEF_ORG_Y
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       frame_req,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] cell_addr,
  output logic       cell_rd,
  input  logic [2:0] cell_data,
  output logic       box_start,
  output logic [9:0] box_x,
  output logic [8:0] box_y,
  output logic [8:0] box_color,
  input  logic       box_done
);

  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);

  state_e           r_state;
  state_e           w_next;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic [7:0]       r_addr;
  logic [9:0]       r_x;
  logic [8:0]       r_y;
  logic [8:0]       r_color;
  logic [8:0]       w_pal;
  logic             w_last;

  tetris_palette u_palette (
    .i_idx   (cell_data),
    .o_color (w_pal)
  );

  assign w_last = (r_col == COL_W'(COLS - 1)) && (r_row == ROW_W'(ROWS - 1));

  // Position is tracked by running accumulators so no multiplier is needed.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_col   <= '0;
      r_row   <= '0;
      r_addr  <= '0;
      r_x     <= 10'(ORG_X);
      r_y     <= 9'(ORG_Y);
      r_color <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_LATCH: r_color <= w_pal;
        ST_ADV: begin
          if (!w_last) begin
            r_addr <= r_addr + 8'd1;
            if (r_col == COL_W'(COLS - 1)) begin
              r_col <= '0;
              r_row <= r_row + ROW_W'(1);
              r_x   <= 10'(ORG_X);
              r_y   <= r_y + 9'(CELL);
            end else begin
              r_col <= r_col + COL_W'(1);
              r_x   <= r_x + 10'(CELL);
            end
          end
        end
        ST_FIN: begin
          r_col  <= '0;
          r_row  <= '0;
          r_addr <= '0;
          r_x    <= 10'(ORG_X);
          r_y    <= 9'(ORG_Y);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next     = r_state;
    busy       = 1'b0;
    frame_done = 1'b0;
    cell_rd    = 1'b0;
    box_start  = 1'b0;
    case (r_state)
      ST_IDLE: if (frame_req) w_next = ST_RD;
      ST_RD: begin
        busy    = 1'b1;
        cell_rd = 1'b1;
        w_next  = ST_LATCH;
      end
      ST_LATCH: begin
        busy   = 1'b1;
        w_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        busy      = 1'b1;
        box_start = 1'b1;
        w_next    = ST_WAIT;
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (box_done) w_next = ST_ADV;
      end
      ST_ADV: begin
        busy   = 1'b1;
        w_next = w_last ? ST_FIN : ST_RD;
      end
      ST_FIN: begin
        frame_done = 1'b1;
        w_next     = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign cell_addr = r_addr;
  assign box_x     = r_x;
  assign box_y     = r_y;
  assign box_color = r_color;

endmodule

// File: tb/tb_board_draw_seq.sv
// Directed bench for board_draw_seq with a board-memory model and a renderer
// model that answers each box_start with box_done five cycles later.
module tb_board_draw_seq;

  localparam int COLS     = 10;
  localparam int ROWS     = 20;
  localparam int CELL     = 20;
  localparam int ORG_X    = 220;
  localparam int ORG_Y    = 40;
  localparam int DONE_DLY = 5;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       frame_req = 1'b0;
  logic       busy, frame_done, cell_rd, box_start, box_done;
  logic [7:0] cell_addr;
  logic [2:0] cell_data;
  logic [9:0] box_x;
  logic [8:0] box_y, box_color;

  logic       mdl_done = 1'b0;
  logic       spur_done = 1'b0;
  logic       mdl_en = 1'b0;
  logic [2:0] board [0:255];
  logic [7:0] addr_q = 8'd0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [8:0] pal_exp [0:7] = '{9'b000_000_000, 9'b000_111_111, 9'b111_111_000,
                                9'b101_000_111, 9'b000_111_000, 9'b111_000_000,
                                9'b000_000_111, 9'b111_100_000};

  board_draw_seq #(
    .COLS(COLS), .ROWS(ROWS), .CELL(CELL), .ORG_X(ORG_X), .ORG_Y(ORG_Y)
  ) dut (
    .CLOCK_50   (clk),
    .resetn     (resetn),
    .frame_req  (frame_req),
    .busy       (busy),
    .frame_done (frame_done),
    .cell_addr  (cell_addr),
    .cell_rd    (cell_rd),
    .cell_data  (cell_data),
    .box_start  (box_start),
    .box_x      (box_x),
    .box_y      (box_y),
    .box_color  (box_color),
    .box_done   (box_done)
  );

  always #5 clk = ~clk;

  initial begin
    if (ORG_X + COLS * CELL > 640 || ORG_Y + ROWS * CELL > 480)
      $fatal(1, "playfield geometry exceeds the 640x480 frame");
  end

  assign box_done  = mdl_done | spur_done;
  assign cell_data = board[addr_q];

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (cell_rd) addr_q <= cell_addr;

  // Monitor and renderer model, sampled on the falling edge.
  int         fs_idx = 0, exp_addr = 0, addr_err = 0, hold_err = 0;
  int         n_done = 0, done_starts = 0, done_cyc = 0;
  int         low_cnt = 0, last_low = 0, mdl_cnt = 0;
  int         st_cyc [0:255];
  logic [9:0] xs [0:255];
  logic [8:0] ys [0:255];
  logic [8:0] cs [0:255];
  logic [9:0] hx;
  logic [8:0] hy, hc;
  bit         in_box = 1'b0;

  always @(negedge clk) begin
    if (in_box && !box_start && busy) begin
      if (box_x !== hx || box_y !== hy || box_color !== hc) hold_err++;
    end
    if (mdl_done || !busy) in_box = 1'b0;
    if (box_start) begin
      if (fs_idx < 256) begin
        xs[fs_idx] = box_x;
        ys[fs_idx] = box_y;
        cs[fs_idx] = box_color;
        st_cyc[fs_idx] = cyc;
      end
      fs_idx++;
      in_box = 1'b1;
      hx = box_x;
      hy = box_y;
      hc = box_color;
    end
    if (cell_rd) begin
      if (cell_addr !== exp_addr[7:0]) addr_err++;
      exp_addr++;
    end
    if (frame_done) begin
      n_done++;
      done_starts = fs_idx;
      done_cyc = cyc;
    end
    if (!busy) begin
      fs_idx = 0;
      exp_addr = 0;
    end
    if (busy) begin
      if (low_cnt > 0) last_low = low_cnt;
      low_cnt = 0;
    end else if (!frame_done) begin
      low_cnt++;
    end
    mdl_done = 1'b0;
    if (mdl_cnt != 0) begin
      mdl_cnt--;
      if (mdl_cnt == 0) mdl_done = 1'b1;
    end
    if (box_start && mdl_en) mdl_cnt = DONE_DLY;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_req();
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int base = n_done;
    int k = 0;
    while (n_done == base && k < maxc) begin
      tick();
      k++;
    end
    chk(tag, 32'(n_done != base), 32'd1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, base, w, f;
    for (int i = 0; i < 256; i++) board[i] = 3'd0;

    // Reset and idle
    resetn = 1'b0;
    tick(3);
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_busy", busy, 0);
      chk("idle_start", box_start, 0);
      chk("idle_rd", cell_rd, 0);
      chk("idle_x", box_x, ORG_X);
      chk("idle_y", box_y, ORG_Y);
    end
    chk("idle_addr", cell_addr, 0);
    chk("idle_color", box_color, 0);
    chk("idle_fdone", frame_done, 0);

    // All-empty board
    mdl_en = 1'b1;
    base = n_done;
    t = cyc;
    pulse_req();
    wait_done("f1_done", 4000);
    tick(3);
    chk("f1_first_lat", st_cyc[0], t + 3);
    chk("f1_x0", xs[0], 220);
    chk("f1_y0", ys[0], 40);
    chk("f1_c0", cs[0], 0);
    chk("f1_count", done_starts, 200);
    chk("f1_x_last", xs[199], 400);
    chk("f1_y_last", ys[199], 420);
    chk("f1_gap", st_cyc[1] - st_cyc[0], 9);
    chk("f1_fin_lat", done_cyc, st_cyc[199] + 7);
    chk("f1_ndone", n_done - base, 1);
    chk("f1_addr_seq", addr_err, 0);
    chk("f1_hold", hold_err, 0);
    chk("f1_busy_end", busy, 0);

    // Palette and row-wrap
    for (int i = 0; i < 8; i++) board[i] = 3'(i);
    board[9] = 3'd3;
    board[10] = 3'd5;
    pulse_req();
    wait_done("f2_done", 4000);
    tick(2);
    for (int i = 0; i < 8; i++) chk("f2_palette", cs[i], pal_exp[i]);
    chk("f2_c8", cs[8], 0);
    chk("f2_x9", xs[9], 400);
    chk("f2_y9", ys[9], 40);
    chk("f2_c9", cs[9], 9'b101_000_111);
    chk("f2_x10", xs[10], 220);
    chk("f2_y10", ys[10], 60);
    chk("f2_c10", cs[10], 9'b111_000_000);
    chk("f2_y20", ys[20], 80);

    // Re-requests and spurious done while busy
    for (int i = 0; i < 256; i++) board[i] = 3'd0;
    base = n_done;
    pulse_req();
    for (int k = 0; k < 6; k++) begin
      w = 0;
      while (!cell_rd && w < 50) begin
        tick();
        w++;
      end
      chk("f3_rd_seen", cell_rd, 1);
      spur_done = 1'b1;
      frame_req = 1'b1;
      tick(2);
      spur_done = 1'b0;
      frame_req = 1'b0;
    end
    w = 0;
    while (!box_start && w < 50) begin
      tick();
      w++;
    end
    chk("f3_issue_seen", box_start, 1);
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    wait_done("f3_done", 4000);
    tick(3);
    chk("f3_count", done_starts, 200);
    chk("f3_ndone", n_done - base, 1);
    chk("f3_addr_seq", addr_err, 0);
    chk("f3_span", st_cyc[199] - st_cyc[0], 199 * 9);
    chk("f3_busy_end", busy, 0);

    // Reset during the 57th WAIT
    board[56] = 3'd7;
    base = n_done;
    pulse_req();
    w = 0;
    while (fs_idx < 57 && w < 2000) begin
      tick();
      w++;
    end
    chk("f4_reach57", fs_idx, 57);
    chk("f4_pre_color", box_color, 9'b111_100_000);
    chk("f4_pre_busy", busy, 1);
    resetn = 1'b0;
    tick();
    chk("f4_rst_busy", busy, 0);
    chk("f4_rst_fdone", frame_done, 0);
    chk("f4_rst_start", box_start, 0);
    chk("f4_rst_rd", cell_rd, 0);
    chk("f4_rst_addr", cell_addr, 0);
    chk("f4_rst_x", box_x, ORG_X);
    chk("f4_rst_y", box_y, ORG_Y);
    chk("f4_rst_color", box_color, 0);
    resetn = 1'b1;
    tick(15);
    chk("f4_no_fdone", n_done - base, 0);
    chk("f4_idle_busy", busy, 0);
    pulse_req();
    chk("f4_re_rd", cell_rd, 1);
    chk("f4_re_addr", cell_addr, 0);
    chk("f4_re_x", box_x, 220);
    chk("f4_re_y", box_y, 40);
    tick(2);
    chk("f4_re_start", box_start, 1);
    wait_done("f4_done", 4000);
    tick(2);
    chk("f4_count", done_starts, 200);
    chk("f4_addr_seq", addr_err, 0);
    chk("f4_ndone", n_done - base, 1);

    // frame_req held across two frames
    base = n_done;
    frame_req = 1'b1;
    wait_done("f5_done1", 4000);
    f = done_cyc;
    w = 0;
    while (fs_idx < 1 && w < 20) begin
      tick();
      w++;
    end
    chk("f5_restart_lat", st_cyc[0] - f, 4);
    chk("f5_low_gap", last_low, 1);
    frame_req = 1'b0;
    wait_done("f5_done2", 4000);
    tick(5);
    chk("f5_count", done_starts, 200);
    chk("f5_ndone", n_done - base, 2);
    chk("f5_busy_end", busy, 0);
    chk("f5_hold", hold_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
